// File: rtl/biss_sample_packer.sv
// rtl/biss_sample_packer.sv - packs timestamped BiSS-C position samples into 3-word AXI-Stream frames

module biss_sample_packer #(
    parameter int POS_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         axis_aclk,
    input  logic                         axis_aresetn,
    input  logic                         en,
    input  logic                         sample_valid,
    input  logic [POS_WIDTH-1:0]         sample_pos,
    input  logic                         sample_crc_ok,
    input  logic                         sample_err,
    input  logic                         sample_warn,
    output logic                         m_axis_tvalid,
    output logic [31:0]                  m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic [3:0]                   m_axis_tkeep,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [15:0]                  drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    state_t state, next_state;

    logic [31:0]          timestamp;
    logic [15:0]          seq;
    logic [AW:0]          wr_ptr, rd_ptr, level;
    logic                 empty, full, handshake, pop, push, drop;

    logic [31:0]          mem_ts    [DEPTH];
    logic [POS_WIDTH-1:0] mem_pos   [DEPTH];
    logic [2:0]           mem_flags [DEPTH];
    logic [15:0]          mem_seq   [DEPTH];

    logic [31:0]          hold_pos;
    logic [31:0]          hold_status;

    assign level      = wr_ptr - rd_ptr;
    assign empty      = (level == '0);
    assign full       = (level == FULL_LEVEL);
    assign fifo_level = level;
    assign handshake  = m_axis_tvalid && m_axis_tready;

    // A full FIFO still takes a sample when a frame leaves on the same edge.
    assign push = sample_valid && en && (!full || pop);
    assign drop = sample_valid && en && !push;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = W0;
                end
            end
            W0: if (handshake) next_state = W1;
            W1: if (handshake) next_state = W2;
            W2: begin
                if (handshake) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = W0;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (push) begin
            mem_ts[wr_ptr[AW-1:0]]    <= timestamp;
            mem_pos[wr_ptr[AW-1:0]]   <= sample_pos;
            mem_flags[wr_ptr[AW-1:0]] <= {sample_warn, sample_err, sample_crc_ok};
            mem_seq[wr_ptr[AW-1:0]]   <= seq;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            timestamp  <= '0;
            seq        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
        end else begin
            timestamp <= timestamp + 32'd1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Word0 is driven straight from the FIFO; words 1 and 2 come from the holding registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            hold_pos      <= '0;
            hold_status   <= '0;
        end else if (pop) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= mem_ts[rd_ptr[AW-1:0]];
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= 4'hF;
            hold_pos      <= 32'(mem_pos[rd_ptr[AW-1:0]]);
            hold_status   <= {mem_seq[rd_ptr[AW-1:0]], 13'b0, mem_flags[rd_ptr[AW-1:0]]};
        end else if (handshake) begin
            case (state)
                W0: m_axis_tdata <= hold_pos;
                W1: begin
                    m_axis_tdata <= hold_status;
                    m_axis_tlast <= 1'b1;
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tdata  <= '0;
                    m_axis_tlast  <= 1'b0;
                    m_axis_tkeep  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biss_sample_packer.sv
// tb/tb_biss_sample_packer.sv - self-checking bench for biss_sample_packer with a frame-queue reference model

module tb_biss_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_pos = '0;
    logic        sample_crc_ok = 1'b0;
    logic        sample_err = 1'b0;
    logic        sample_warn = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tkeep;
    logic [2:0]  fifo_level;
    logic [15:0] drop_count;

    biss_sample_packer #(.POS_WIDTH(24), .DEPTH(4)) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .en            (en),
        .sample_valid  (sample_valid),
        .sample_pos    (sample_pos),
        .sample_crc_ok (sample_crc_ok),
        .sample_err    (sample_err),
        .sample_warn   (sample_warn),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] rx[$];
    logic [32:0] exp_q[$];
    int          ts_m = 0;
    int          seq_m = 0;
    int          drops_m = 0;
    bit          rdy_rand = 1'b0;
    bit          rdy_val = 1'b0;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, monitor the stream, update the model, return #1 after the edge.
    task automatic tick(input bit sv = 0, input logic [23:0] pos = '0, input bit crc = 0,
                        input bit er = 0, input bit wr = 0, input bit drop = 0);
        @(negedge clk);
        sample_valid  = sv;
        sample_pos    = pos;
        sample_crc_ok = crc;
        sample_err    = er;
        sample_warn   = wr;
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        chk("tkeep", {29'b0, m_axis_tkeep}, m_axis_tvalid ? 33'hF : 33'h0);
        if (m_axis_tvalid && m_axis_tready) rx.push_back({m_axis_tlast, m_axis_tdata});
        if (sv && en && rst_n) begin
            if (drop) begin
                if (drops_m < 65535) drops_m++;
            end else begin
                exp_q.push_back({1'b0, 32'(ts_m)});
                exp_q.push_back({1'b0, 8'b0, pos});
                exp_q.push_back({1'b1, 16'(seq_m), 13'b0, wr, er, crc});
                seq_m = (seq_m + 1) % 65536;
            end
        end
        @(posedge clk);
        #1;
        if (rst_n) ts_m++;
    endtask

    task automatic drain();
        for (int b = 0; b < 300 && rx.size() < exp_q.size(); b++) tick();
        tick();
        tick();
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 33'(rx.size()), 33'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), rx[i], exp_q[i]);
        rx.delete();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] p;
        int          n;

        #12;
        chk("rst_tvalid", 33'(m_axis_tvalid), 33'h0);
        chk("rst_tdata", 33'(m_axis_tdata), 33'h0);
        chk("rst_tlast", 33'(m_axis_tlast), 33'h0);
        chk("rst_level", 33'(fifo_level), 33'h0);
        chk("rst_drops", 33'(drop_count), 33'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ts_m  = 0;

        // Single sample at timestamp 100
        en      = 1'b1;
        rdy_val = 1'b1;
        while (ts_m < 100) tick();
        tick(1, 24'hABCDEF, 1, 0, 0);
        chk("lat_not_yet", 33'(m_axis_tvalid), 33'h0);
        tick();
        chk("lat_valid", 33'(m_axis_tvalid), 33'h1);
        chk("w0_ts100", 33'(m_axis_tdata), 33'd100);
        drain();
        check_rx("single");
        chk("single_drops", 33'(drop_count), 33'(drops_m));

        // Backpressure on word1
        p = 24'($urandom);
        tick(1, p, 1, 1, 0);
        tick();
        tick();
        chk("bp_word1", 33'(m_axis_tdata), {9'b0, p});
        rdy_val = 1'b0;
        tick();
        chk("bp_hold1", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'b0, p});
        tick();
        chk("bp_hold2", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'b0, p});
        chk("bp_nolast", 33'(m_axis_tlast), 33'h0);
        rdy_val = 1'b1;
        tick();
        chk("bp_last", 33'(m_axis_tlast), 33'h1);
        tick();
        chk("bp_idle_valid", 33'(m_axis_tvalid), 33'h0);
        drain();
        check_rx("backpressure");

        // Overflow: 7 back-to-back samples, output stalled
        rdy_val = 1'b0;
        for (int i = 0; i < 7; i++)
            tick(1, 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), i >= 5);
        chk("ovf_drops", 33'(drop_count), 33'(drops_m));
        chk("ovf_level", 33'(fifo_level), 33'd4);
        chk("ovf_valid", 33'(m_axis_tvalid), 33'h1);
        rdy_val = 1'b1;
        drain();
        check_rx("overflow");

        // Full FIFO, pop and write on the same edge
        rdy_val = 1'b0;
        for (int i = 0; i < 5; i++) tick(1, 24'($urandom), 1, 0, 1);
        chk("fpw_full", 33'(fifo_level), 33'd4);
        rdy_val = 1'b1;
        tick();
        tick();
        chk("fpw_in_w2", {m_axis_tvalid, m_axis_tlast}, 33'h3);
        tick(1, 24'($urandom), 0, 1, 1);
        chk("fpw_level", 33'(fifo_level), 33'd4);
        chk("fpw_drops", 33'(drop_count), 33'(drops_m));
        drain();
        check_rx("fullpopwrite");

        // en=0 ignores strobes; a frame in flight completes while en is low
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1, 24'($urandom), 1, 1, 1);
            tick();
        end
        tick();
        chk("en0_valid", 33'(m_axis_tvalid), 33'h0);
        chk("en0_drops", 33'(drop_count), 33'(drops_m));
        check_rx("en0");
        en = 1'b1;
        tick(1, 24'($urandom), 1, 0, 0);
        tick();
        en = 1'b0;
        tick(1, 24'($urandom), 0, 0, 0);
        tick(1, 24'($urandom), 0, 0, 0);
        drain();
        en = 1'b1;
        check_rx("en_middrain");

        // Randomised bursts that never exceed the 5-frame capacity
        rdy_rand = 1'b1;
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, 5);
            for (int s = 0; s < n; s++) begin
                en = ($urandom_range(0, 3) != 0);
                tick(1, 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            end
            en = 1'b1;
            drain();
            check_rx($sformatf("burst%0d", b));
            chk("burst_drops", 33'(drop_count), 33'(drops_m));
        end
        rdy_rand = 1'b0;

        // Reset asserted while word1 is on the bus
        rdy_val = 1'b1;
        tick(1, 24'h123456, 1, 0, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 33'(m_axis_tvalid), 33'h0);
        chk("mid_rst_data", 33'(m_axis_tdata), 33'h0);
        chk("mid_rst_level", 33'(fifo_level), 33'h0);
        chk("mid_rst_drops", 33'(drop_count), 33'h0);
        rx.delete();
        exp_q.delete();
        seq_m   = 0;
        drops_m = 0;
        ts_m    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1, 24'h00BEEF, 0, 1, 0);
        tick();
        chk("post_rst_ts0", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'd0});
        drain();
        check_rx("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
